// File: rtl/tpu_job_scheduler_if.sv
// Host command, TPU launch and done-report channels of the job scheduler.
interface tpu_job_scheduler_if #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [7:0]           cmd_k;
    logic [7:0]           cmd_m;
    logic [7:0]           cmd_n;
    logic [TAG_W-1:0]     cmd_tag;
    logic                 tpu_in_valid;
    logic [7:0]           tpu_k;
    logic [7:0]           tpu_m;
    logic [7:0]           tpu_n;
    logic                 tpu_busy;
    logic                 done_valid;
    logic                 done_ready;
    logic [TAG_W-1:0]     done_tag;
    logic [1:0]           done_status;
    logic [23:0]          done_cycles;
    logic                 host_buf_own;
    logic [$clog2(DEPTH):0] q_level;

    modport slave (
        input  cmd_valid, cmd_k, cmd_m, cmd_n, cmd_tag,
        input  tpu_busy, done_ready,
        output cmd_ready, tpu_in_valid, tpu_k, tpu_m, tpu_n,
        output done_valid, done_tag, done_status, done_cycles,
        output host_buf_own, q_level
    );

    modport master (
        output cmd_valid, cmd_k, cmd_m, cmd_n, cmd_tag,
        output tpu_busy, done_ready,
        input  cmd_ready, tpu_in_valid, tpu_k, tpu_m, tpu_n,
        input  done_valid, done_tag, done_status, done_cycles,
        input  host_buf_own, q_level
    );
endinterface

// File: rtl/tpu_job_scheduler.sv
// Command FIFO plus one-job-at-a-time launch FSM for the 4x4 systolic TPU.
// Define TPU_SCHED_PERF_EN to report per-job cycle counts in done_cycles.
module tpu_job_scheduler #(
    parameter int DEPTH         = 4,
    parameter int START_TIMEOUT = 15,
    parameter int TAG_W         = 4
) (
    input  logic               clk,
    input  logic               rst,
    tpu_job_scheduler_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 24 + TAG_W;
    localparam int TW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, LAUNCH, WAIT_START, RUN, REPORT
    } state_t;

    state_t           state_q, state_d;
    logic [EW-1:0]    mem_q [DEPTH];
    logic [EW-1:0]    mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [7:0]       k_q, k_d, m_q, m_d, n_q, n_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [TAG_W-1:0] done_tag_q, done_tag_d;
    logic [1:0]       status_q, status_d;
    logic             in_valid_q, in_valid_d;
    logic             own_q, own_d;
    logic             done_valid_q, done_valid_d;
    logic [TW-1:0]    wait_q, wait_d;
    logic             full, empty, push, pop, head_zero;
    logic [EW-1:0]    head;

    // Entry layout: {tag, n, m, k}
    assign full      = count_q == (AW+1)'(DEPTH);
    assign empty     = count_q == '0;
    assign push      = bus.cmd_valid && !full;
    assign pop       = (state_q == IDLE) && !empty;
    assign head      = mem_q[rd_ptr_q];
    assign head_zero = head[7:0] == '0 || head[15:8] == '0
                    || head[23:16] == '0;

    always_comb begin
        state_d      = state_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        k_d          = k_q;
        m_d          = m_q;
        n_d          = n_q;
        tag_d        = tag_q;
        done_tag_d   = done_tag_q;
        status_d     = status_q;
        in_valid_d   = 1'b0;
        own_d        = own_q;
        done_valid_d = done_valid_q;
        wait_d       = wait_q;
        if (push) begin
            mem_d[wr_ptr_q] = {bus.cmd_tag, bus.cmd_n,
                               bus.cmd_m, bus.cmd_k};
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + {{AW{1'b0}}, push}
                          - {{AW{1'b0}}, pop};
        unique case (state_q)
            IDLE: if (pop) begin
                // A zero dimension would hang the TPU: report, never launch
                if (head_zero) begin
                    done_tag_d   = head[EW-1:24];
                    status_d     = 2'd1;
                    done_valid_d = 1'b1;
                    state_d      = REPORT;
                end else begin
                    k_d        = head[7:0];
                    m_d        = head[15:8];
                    n_d        = head[23:16];
                    tag_d      = head[EW-1:24];
                    in_valid_d = 1'b1;
                    own_d      = 1'b0;
                    state_d    = LAUNCH;
                end
            end
            LAUNCH: begin
                wait_d  = '0;
                state_d = WAIT_START;
            end
            WAIT_START: begin
                if (bus.tpu_busy) begin
                    state_d = RUN;
                end else if (wait_q == TW'(START_TIMEOUT - 1)) begin
                    done_tag_d   = tag_q;
                    status_d     = 2'd2;
                    done_valid_d = 1'b1;
                    own_d        = 1'b1;
                    state_d      = REPORT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            RUN: if (!bus.tpu_busy) begin
                done_tag_d   = tag_q;
                status_d     = 2'd0;
                done_valid_d = 1'b1;
                own_d        = 1'b1;
                state_d      = REPORT;
            end
            REPORT: if (bus.done_ready) begin
                done_valid_d = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            k_q          <= '0;
            m_q          <= '0;
            n_q          <= '0;
            tag_q        <= '0;
            done_tag_q   <= '0;
            status_q     <= '0;
            in_valid_q   <= 1'b0;
            own_q        <= 1'b1;
            done_valid_q <= 1'b0;
            wait_q       <= '0;
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            k_q          <= k_d;
            m_q          <= m_d;
            n_q          <= n_d;
            tag_q        <= tag_d;
            done_tag_q   <= done_tag_d;
            status_q     <= status_d;
            in_valid_q   <= in_valid_d;
            own_q        <= own_d;
            done_valid_q <= done_valid_d;
            wait_q       <= wait_d;
        end
    end

`ifdef TPU_SCHED_PERF_EN
    logic [23:0] cnt_q, cnt_d, cyc_q, cyc_d;

    always_comb begin
        cnt_d = cnt_q;
        cyc_d = cyc_q;
        if (state_d == LAUNCH && state_q != LAUNCH)
            cnt_d = '0;
        else if ((state_q == LAUNCH || state_q == WAIT_START
                  || state_q == RUN) && cnt_q != 24'hFFFFFF)
            cnt_d = cnt_q + 24'd1;
        // Rejects come straight from IDLE and never ran
        if (state_d == REPORT && state_q != REPORT)
            cyc_d = (state_q == IDLE) ? '0 : cnt_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            cyc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            cyc_q <= cyc_d;
        end
    end

    assign bus.done_cycles = cyc_q;
`else
    assign bus.done_cycles = '0;
`endif

    assign bus.cmd_ready    = !full;
    assign bus.tpu_in_valid = in_valid_q;
    assign bus.tpu_k        = k_q;
    assign bus.tpu_m        = m_q;
    assign bus.tpu_n        = n_q;
    assign bus.done_valid   = done_valid_q;
    assign bus.done_tag     = done_tag_q;
    assign bus.done_status  = status_q;
    assign bus.host_buf_own = own_q;
    assign bus.q_level      = count_q;
endmodule

// File: tb/tb_tpu_job_scheduler.sv
// Directed, table-driven bench for tpu_job_scheduler with a simple TPU busy model.
module tb_tpu_job_scheduler;
`ifdef TPU_SCHED_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   busy_len = 0;
    int   left = 0;
    int   launches = 0;
    int   viol = 0;

    tpu_job_scheduler_if #(.DEPTH(4), .TAG_W(4)) bus ();

    tpu_job_scheduler #(
        .DEPTH(4), .START_TIMEOUT(15), .TAG_W(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // TPU: busy rises the cycle after in_valid, stays high busy_len cycles
    always @(posedge clk) begin
        if (rst) begin
            bus.tpu_busy <= 1'b0;
            left <= 0;
        end else if (bus.tpu_in_valid && busy_len != 0) begin
            bus.tpu_busy <= 1'b1;
            left <= busy_len - 1;
        end else if (left != 0) begin
            left <= left - 1;
        end else begin
            bus.tpu_busy <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (bus.tpu_in_valid) launches <= launches + 1;
        if (bus.tpu_in_valid && bus.tpu_busy) viol <= viol + 1;
    end

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive_cmd(input logic [7:0] k, m, n,
                             input logic [3:0] tag);
        bus.cmd_valid = 1'b1;
        bus.cmd_k = k;
        bus.cmd_m = m;
        bus.cmd_n = n;
        bus.cmd_tag = tag;
    endtask

    typedef struct {
        logic [7:0] k, m, n;
        logic [3:0] tag;
        int busy;
        int launch;
        int status;
        int lat;
        int cyc;
    } vec_t;

    vec_t vec[7];
    int   tags[5];

    initial begin
        int n, l0, nd, lvl_max;
        bit bad;
        vec[0] = '{8'd8,   8'd4,   8'd4,   4'd3,  40, 1, 0, 42, 42};
        vec[1] = '{8'd0,   8'd4,   8'd4,   4'd7,   0, 0, 1,  0,  0};
        vec[2] = '{8'd1,   8'd1,   8'd1,   4'd5,   1, 1, 0,  3,  3};
        vec[3] = '{8'd4,   8'd0,   8'd2,   4'd9,   0, 0, 1,  0,  0};
        vec[4] = '{8'd2,   8'd3,   8'd4,   4'd12,  0, 1, 2, 16, 16};
        vec[5] = '{8'd255, 8'd255, 8'd255, 4'd15, 10, 1, 0, 12, 12};
        vec[6] = '{8'd3,   8'd3,   8'd0,   4'd0,   0, 0, 1,  0,  0};

        bus.cmd_valid = 1'b0;
        bus.cmd_k = '0;
        bus.cmd_m = '0;
        bus.cmd_n = '0;
        bus.cmd_tag = '0;
        bus.done_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_own", bus.host_buf_own, 1);
        chk("rst_done_valid", bus.done_valid, 0);
        chk("rst_in_valid", bus.tpu_in_valid, 0);
        chk("rst_q_level", bus.q_level, 0);
        chk("rst_done_tag", bus.done_tag, 0);
        chk("rst_status", bus.done_status, 0);
        chk("rst_cycles", bus.done_cycles, 0);
        chk("rst_tpu_k", bus.tpu_k, 0);

        for (int i = 0; i < 7; i++) begin
            busy_len = vec[i].busy;
            l0 = launches;
            drive_cmd(vec[i].k, vec[i].m, vec[i].n, vec[i].tag);
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            chk("v_q_level", bus.q_level, 1);
            chk("v_early_launch", bus.tpu_in_valid, 0);
            @(negedge clk);
            chk("v_launch_t2", bus.tpu_in_valid, vec[i].launch);
            chk("v_own_launch", bus.host_buf_own,
                (vec[i].launch == 0) ? 1 : 0);
            if (vec[i].launch != 0) begin
                chk("v_tpu_k", bus.tpu_k, vec[i].k);
                chk("v_tpu_n", bus.tpu_n, vec[i].n);
            end
            n = 0;
            bad = 1'b0;
            while (!bus.done_valid && n < 200) begin
                if (bus.host_buf_own) bad = 1'b1;
                @(negedge clk);
                n++;
            end
            chk("v_done_valid", bus.done_valid, 1);
            chk("v_latency", n, vec[i].lat);
            chk("v_done_tag", bus.done_tag, vec[i].tag);
            chk("v_status", bus.done_status, vec[i].status);
            chk("v_cycles", bus.done_cycles,
                PERF ? vec[i].cyc : 0);
            chk("v_own_report", bus.host_buf_own, 1);
            chk("v_own_while_run", bad, 0);
            chk("v_launch_count", launches - l0, vec[i].launch);
            bus.done_ready = 1'b1;
            @(negedge clk);
            bus.done_ready = 1'b0;
            chk("v_done_drop", bus.done_valid, 0);
        end

        // Queue fill: five back-to-back jobs into a 4-deep FIFO
        busy_len = 6;
        bus.done_ready = 1'b1;
        lvl_max = 0;
        nd = 0;
        for (int j = 0; j < 5; j++) begin
            drive_cmd(8'(j + 1), 8'd2, 8'd3, 4'(j + 1));
            chk("fill_ready", bus.cmd_ready, 1);
            @(negedge clk);
            if (int'(bus.q_level) > lvl_max) lvl_max = bus.q_level;
        end
        bus.cmd_valid = 1'b0;
        chk("fill_full_ready", bus.cmd_ready, 0);
        chk("fill_level", bus.q_level, 4);
        n = 0;
        while (nd < 5 && n < 1000) begin
            if (int'(bus.q_level) > lvl_max) lvl_max = bus.q_level;
            if (bus.done_valid) begin
                tags[nd] = int'(bus.done_tag);
                nd++;
            end
            @(negedge clk);
            n++;
        end
        bus.done_ready = 1'b0;
        chk("fill_done_count", nd, 5);
        for (int j = 0; j < 5; j++)
            chk("fill_tag_order", tags[j], j + 1);
        chk("fill_level_max", lvl_max, 4);
        chk("fill_drained", bus.q_level, 0);
        chk("fill_ready_back", bus.cmd_ready, 1);
        chk("launch_while_busy", viol, 0);

        // Back-pressure on done, then reset during the next job's RUN
        busy_len = 5;
        drive_cmd(8'd2, 8'd2, 8'd2, 4'd6);
        @(negedge clk);
        drive_cmd(8'd3, 8'd3, 8'd3, 4'd8);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (!bus.done_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_done_valid", bus.done_valid, 1);
        l0 = launches;
        bad = 1'b0;
        repeat (20) begin
            if (!bus.done_valid || bus.done_tag != 4'd6
                || bus.done_status != 2'd0
                || bus.done_cycles != (PERF ? 24'd7 : 24'd0))
                bad = 1'b1;
            @(negedge clk);
        end
        chk("bp_fields_stable", bad, 0);
        chk("bp_no_launch", launches - l0, 0);
        chk("bp_q_level", bus.q_level, 1);
        chk("bp_own", bus.host_buf_own, 1);
        bus.done_ready = 1'b1;
        @(negedge clk);
        bus.done_ready = 1'b0;
        n = 0;
        while (!bus.tpu_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rr_busy_seen", bus.tpu_busy, 1);
        @(negedge clk);
        drive_cmd(8'd4, 8'd4, 8'd4, 4'd11);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("rr_q_before", bus.q_level, 1);
        chk("rr_own_run", bus.host_buf_own, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rr_q_level", bus.q_level, 0);
        chk("rr_done_valid", bus.done_valid, 0);
        chk("rr_own", bus.host_buf_own, 1);
        chk("rr_cmd_ready", bus.cmd_ready, 1);
        chk("rr_in_valid", bus.tpu_in_valid, 0);
        l0 = launches;
        repeat (5) @(negedge clk);
        chk("rr_idle_quiet", launches - l0, 0);
        chk("rr_no_done", bus.done_valid, 0);

        busy_len = 3;
        drive_cmd(8'd1, 8'd1, 8'd1, 4'd10);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (!bus.done_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rec_done_valid", bus.done_valid, 1);
        chk("rec_tag", bus.done_tag, 10);
        chk("rec_status", bus.done_status, 0);
        bus.done_ready = 1'b1;
        @(negedge clk);
        bus.done_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tpu_job_scheduler.md
Name: tpu_job_scheduler

Overview:
- Queues GEMM jobs (K, M, N plus a tag) from the host control path and launches them one at a time on the 4x4 systolic TPU core using its in_valid/busy handshake.
- Reports per-job completion and status on a valid/ready done channel.
- Decides who owns the shared A/B/C global buffers: the host when the TPU is idle, the TPU while a job runs.
- Sits between the host register/command interface and the TPU core.

Parameters:
- DEPTH, 4, number of command FIFO entries (power of 2, at least 2)
- START_TIMEOUT, 15, maximum cycles to wait for tpu_busy to rise after launch
- TAG_W, 4, width of the job tag

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  host offers a job
- cmd_ready  out  1  FIFO can accept a job
- cmd_k  in  8  job K
- cmd_m  in  8  job M
- cmd_n  in  8  job N
- cmd_tag  in  TAG_W  job identifier
- tpu_in_valid  out  1  one-cycle launch pulse to TPU
- tpu_k  out  8  K to TPU, held stable from launch until next launch
- tpu_m  out  8  M to TPU, held stable from launch until next launch
- tpu_n  out  8  N to TPU, held stable from launch until next launch
- tpu_busy  in  1  TPU busy flag
- done_valid  out  1  completion record available
- done_ready  in  1  host consumes completion record
- done_tag  out  TAG_W  tag of completed job
- done_status  out  2  0 = OK, 1 = zero-dimension reject, 2 = start timeout, 3 = reserved
- done_cycles  out  24  job cycle count (see Optional Feature)
- host_buf_own  out  1  1 = host may access A/B/C buffers, 0 = TPU owns them
- q_level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst=1 at a clock edge): FIFO flushed, state=IDLE. All outputs read 0 except host_buf_own=1 and cmd_ready=1 from the first cycle after reset.
- Reset mid-job drops the job with no done record. The system resets the TPU in the same cycle.
- FIFO push:
  - Push occurs on cmd_valid && cmd_ready.
  - cmd_ready = !full. It does not depend on a same-cycle pop.
  - Pushes while full are impossible by construction.
  - Simultaneous push and pop when not full: q_level unchanged.
- States: IDLE, LAUNCH, WAIT_START, RUN, REPORT.
- IDLE:
  - If FIFO empty: stay in IDLE.
  - If head has K, M or N equal to 0: pop the entry, load done_tag/status=1, go to REPORT. No launch; a zero dimension hangs the TPU.
  - Otherwise: pop the entry, register tpu_k/m/n and the tag, go to LAUNCH.
- LAUNCH (exactly 1 cycle): tpu_in_valid=1, then go to WAIT_START.
- WAIT_START:
  - The TPU raises busy one cycle after in_valid. A low busy in this state is not completion.
  - tpu_busy=1: go to RUN.
  - After START_TIMEOUT cycles in this state without busy: status=2, go to REPORT.
- RUN: wait for tpu_busy=0, then status=0 and go to REPORT.
- REPORT:
  - done_valid=1, with tag/status/cycles stable.
  - On done_ready: go to IDLE.
  - done_valid deasserts the cycle after the handshake.
- Latency: a job pushed at edge t with the FIFO previously empty and state IDLE gives tpu_in_valid high during cycle t+2.
- Throughput: at most one job in flight. Minimum 2 cycles between done handshake and the next tpu_in_valid.
- host_buf_own:
  - 1 in IDLE and REPORT, 0 in LAUNCH, WAIT_START and RUN.
  - Registered: falls in the same cycle tpu_in_valid rises.
- tpu_busy seen high while IDLE or REPORT is ignored. It has no effect on state.
- Pointers wrap modulo DEPTH. q_level ranges 0..DEPTH.

Optional Feature:
- Macro TPU_SCHED_PERF_EN.
- Defined:
  - A 24-bit counter clears on entering LAUNCH and increments every cycle in LAUNCH, WAIT_START and RUN.
  - It saturates at 0xFFFFFF.
  - It is latched into done_cycles on entering REPORT.
  - A zero-dimension reject reports 0.
- Not defined: counter is absent and done_cycles is constant 0.

Test Plan:
- Single job: push K=8, M=4, N=4, tag=3 with a TPU model (busy high from 1 cycle after in_valid for 40 cycles). Required: tpu_in_valid one cycle at t+2; host_buf_own=0 until busy falls; done_valid with tag=3, status=0; with PERF done_cycles=42.
- Queue fill: push 5 jobs back-to-back with DEPTH=4 while the first runs. Required: cmd_ready=0 after the FIFO fills, q_level=4 maximum, done tags in push order, no tpu_in_valid while tpu_busy=1.
- Zero dimension: push K=0, M=4, N=4, tag=7. Required: no tpu_in_valid pulse; done status=1, tag=7; the next valid job launches normally.
- Start timeout: TPU model never raises busy. Required: done status=2 exactly START_TIMEOUT cycles after entering WAIT_START; host_buf_own returns to 1.
- Back-pressure and reset: hold done_ready=0 for 20 cycles. Required: done fields stable and no new launch. Then assert rst during RUN of the following job. Required: next cycle state IDLE, q_level=0, done_valid=0, host_buf_own=1.
